// File: rtl/permute_result_pkg.sv
// permute_result_pkg
//   Shared definitions for the permute result accumulator slice: lane word
//   field layout, the accumulator FSM state type, the unpacked lane fields
//   record and the totals record at the default configuration.
//   Lane word layout (bot beat): [63] ECC, [60:48] pcoeff count, [47:0] sum.
//   Lane A word (top beat): [63:32] busy cycles, [31:0] total cycles.
package permute_result_pkg;

  localparam int RESULT_W     = 64;
  localparam int SUM_W        = 48;
  localparam int PCOEFF_LSB   = 48;
  localparam int PCOEFF_W     = 13;
  localparam int ECC_BIT      = 63;
  localparam int OCC_BUSY_LSB = 32;
  localparam int ECC_CNT_W    = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accState_t;

  typedef struct packed {
    logic                ecc;
    logic [PCOEFF_W-1:0] pcoeff;
    logic [SUM_W-1:0]    sum;
  } laneFields_t;

  // Totals record as seen by the host writer at TOTAL_SUM_W=64, TOTAL_CNT_W=32.
  typedef struct packed {
    logic [63:0]          sum;
    logic [31:0]          pcoeff;
    logic [31:0]          botCount;
    logic [RESULT_W-1:0]  occupancy;
    logic [ECC_CNT_W-1:0] eccErrors;
  } totalsRec_t;

endpackage

// File: rtl/permute_result_lane_unpack.sv
// permute_result_lane_unpack
//   Splits one 64-bit bot-result lane word into its summed value, pcoeff count
//   and ECC flag. Bits [62:61] are padding and are not used.
//   Ports:
//     laneWord  in   RESULT_W  raw lane word
//     fields    out  laneFields_t  {ecc, pcoeff, sum}
module permute_result_lane_unpack
  import permute_result_pkg::*;
(
  input  logic [RESULT_W-1:0] laneWord,
  output laneFields_t         fields
);

  assign fields.sum    = laneWord[SUM_W-1:0];
  assign fields.pcoeff = laneWord[PCOEFF_LSB +: PCOEFF_W];
  assign fields.ecc    = laneWord[ECC_BIT];

  logic unusedPad;
  assign unusedPad = ^laneWord[ECC_BIT-1:PCOEFF_LSB+PCOEFF_W];

endmodule

// File: rtl/permute_result_accumulator.sv
// permute_result_accumulator
//   Folds the two-lane bot results belonging to one top into per-top totals and
//   emits one totals record per top over a valid/ready handshake.
//   A top beat opens a new top (closing the previous one if open); flush closes
//   the open top at end of job. Bot beats with no top open are dropped and
//   raise the sticky orphan_error.
//   Optional feature: define PERMUTE_RESULT_ECC_CHECK_EN to count lane ECC flags
//   into out_ecc_errors (saturating); otherwise out_ecc_errors is tied to 0.
//   Ports:
//     clock, rst (sync, active-low)
//     in_valid/in_ready, in_is_top, in_result_a, in_result_b  input beat
//     flush                                                   close open top
//     out_valid/out_ready, out_sum, out_pcoeff, out_bot_count,
//     out_occupancy, out_ecc_errors                            totals record
//     orphan_error                                            sticky error
module permute_result_accumulator
  import permute_result_pkg::*;
#(
  parameter int TOTAL_SUM_W = 64,
  parameter int TOTAL_CNT_W = 32
)
(
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_top,
  input  logic [RESULT_W-1:0]    in_result_a,
  input  logic [RESULT_W-1:0]    in_result_b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_SUM_W-1:0] out_sum,
  output logic [TOTAL_CNT_W-1:0] out_pcoeff,
  output logic [TOTAL_CNT_W-1:0] out_bot_count,
  output logic [RESULT_W-1:0]    out_occupancy,
  output logic [ECC_CNT_W-1:0]   out_ecc_errors,
  output logic                   orphan_error
);

  typedef struct packed {
    logic [TOTAL_SUM_W-1:0] sum;
    logic [TOTAL_CNT_W-1:0] pcoeff;
    logic [TOTAL_CNT_W-1:0] botCount;
    logic [RESULT_W-1:0]    occupancy;
  } totals_t;

  function automatic logic [TOTAL_SUM_W-1:0] zextSum(input logic [SUM_W-1:0] v);
    return {{(TOTAL_SUM_W-SUM_W){1'b0}}, v};
  endfunction

  function automatic logic [TOTAL_CNT_W-1:0] zextCnt(input logic [PCOEFF_W-1:0] v);
    return {{(TOTAL_CNT_W-PCOEFF_W){1'b0}}, v};
  endfunction

  laneFields_t laneA;
  laneFields_t laneB;

  permute_result_lane_unpack uLaneA (
    .laneWord (in_result_a),
    .fields   (laneA)
  );

  permute_result_lane_unpack uLaneB (
    .laneWord (in_result_b),
    .fields   (laneB)
  );

  accState_t state;
  accState_t stateNext;
  logic      topOpen;
  logic      accept;
  logic      outFree;
  logic      flushTake;
  logic      loadOut;

  totals_t   acc_p0;
  totals_t   out_p1;
  logic      vld_p1;
  logic      orphanErr;

  // Input is stalled while flush waits and while a record is blocked, so a
  // flush and an accepted beat never coincide.
  assign in_ready = rst && !flush && !(vld_p1 && !out_ready);

  always_ff @(posedge clock) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && in_is_top) stateNext = ACCUM;
      ACCUM:   if (flushTake)           stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    topOpen   = (state == ACCUM);
    accept    = in_valid && in_ready;
    outFree   = !vld_p1 || out_ready;
    flushTake = rst && flush && topOpen && outFree;
    loadOut   = (accept && in_is_top && topOpen) || flushTake;
  end

  // ---- stage p0: per-top accumulators ----
  always_ff @(posedge clock) begin
    if (!rst) begin
      acc_p0    <= '0;
      orphanErr <= 1'b0;
    end else begin
      if (accept && in_is_top) begin
        acc_p0           <= '0;
        acc_p0.occupancy <= in_result_a;
      end else if (accept && topOpen) begin
        acc_p0.sum      <= acc_p0.sum + zextSum(laneA.sum) + zextSum(laneB.sum);
        acc_p0.pcoeff   <= acc_p0.pcoeff + zextCnt(laneA.pcoeff) + zextCnt(laneB.pcoeff);
        acc_p0.botCount <= acc_p0.botCount + TOTAL_CNT_W'(2);
      end
      if (accept && !in_is_top && !topOpen) begin
        orphanErr <= 1'b1;
      end
    end
  end

  // ---- stage p1: output record register ----
  always_ff @(posedge clock) begin
    if (!rst) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (loadOut) begin
      out_p1 <= acc_p0;
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef PERMUTE_RESULT_ECC_CHECK_EN
  function automatic logic [ECC_CNT_W-1:0] satAddEcc(input logic [ECC_CNT_W-1:0] acc,
                                                     input logic [1:0]           inc);
    logic [ECC_CNT_W:0] s;
    s = {1'b0, acc} + {{(ECC_CNT_W-1){1'b0}}, inc};
    return s[ECC_CNT_W] ? {ECC_CNT_W{1'b1}} : s[ECC_CNT_W-1:0];
  endfunction

  logic [ECC_CNT_W-1:0] eccAcc_p0;
  logic [ECC_CNT_W-1:0] eccOut_p1;

  always_ff @(posedge clock) begin
    if (!rst) begin
      eccAcc_p0 <= '0;
      eccOut_p1 <= '0;
    end else begin
      if (accept && in_is_top) begin
        eccAcc_p0 <= '0;
      end else if (accept && topOpen) begin
        eccAcc_p0 <= satAddEcc(eccAcc_p0, {1'b0, laneA.ecc} + {1'b0, laneB.ecc});
      end
      if (loadOut) begin
        eccOut_p1 <= eccAcc_p0;
      end
    end
  end

  assign out_ecc_errors = eccOut_p1;
`else
  logic unusedEcc;
  assign unusedEcc      = laneA.ecc ^ laneB.ecc;
  assign out_ecc_errors = '0;
`endif

  assign out_valid     = vld_p1;
  assign out_sum       = out_p1.sum;
  assign out_pcoeff    = out_p1.pcoeff;
  assign out_bot_count = out_p1.botCount;
  assign out_occupancy = out_p1.occupancy;
  assign orphan_error  = orphanErr;

endmodule

// File: tb/tb_permute_result_accumulator.sv
module tb_permute_result_accumulator;

`ifdef PERMUTE_RESULT_ECC_CHECK_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_top;
  logic [63:0] in_result_a;
  logic [63:0] in_result_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [31:0] out_pcoeff;
  logic [31:0] out_bot_count;
  logic [63:0] out_occupancy;
  logic [15:0] out_ecc_errors;
  logic        orphan_error;

  always #5 clock = ~clock;

  permute_result_accumulator #(.TOTAL_SUM_W(64), .TOTAL_CNT_W(32)) dut (
    .clock          (clock),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_top      (in_is_top),
    .in_result_a    (in_result_a),
    .in_result_b    (in_result_b),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_pcoeff     (out_pcoeff),
    .out_bot_count  (out_bot_count),
    .out_occupancy  (out_occupancy),
    .out_ecc_errors (out_ecc_errors),
    .orphan_error   (orphan_error)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: open-top totals plus at most one record waiting for the host.
  bit          primed = 1'b0;
  bit          mOpen;
  logic [63:0] mSum;
  logic [31:0] mPc;
  logic [31:0] mBc;
  logic [63:0] mOcc;
  int          mEcc;
  bit          mOrphan;
  bit          mPendV;
  logic [63:0] pSum;
  logic [31:0] pPc;
  logic [31:0] pBc;
  logic [63:0] pOcc;
  logic [15:0] pEcc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic ecc, input logic [12:0] cnt, input logic [47:0] sum);
    return {ecc, 2'b00, cnt, sum};
  endfunction

  task automatic modelReset();
    mOpen = 0; mSum = '0; mPc = '0; mBc = '0; mOcc = '0; mEcc = 0; mOrphan = 0;
    mPendV = 0; pSum = '0; pPc = '0; pBc = '0; pOcc = '0; pEcc = '0;
  endtask

  task automatic modelCheck(input bit expReady);
    if (primed) begin
      chk("in_ready", 64'(in_ready), 64'(expReady));
      chk("out_valid", 64'(out_valid), 64'(mPendV));
      chk("orphan_error", 64'(orphan_error), 64'(mOrphan));
      if (mPendV) begin
        chk("out_sum", out_sum, pSum);
        chk("out_pcoeff", 64'(out_pcoeff), 64'(pPc));
        chk("out_bot_count", 64'(out_bot_count), 64'(pBc));
        chk("out_occupancy", out_occupancy, pOcc);
        chk("out_ecc_errors", 64'(out_ecc_errors), 64'(pEcc));
      end
    end
  endtask

  task automatic modelUpdate(input bit r, input bit taken, input bit t, input logic [63:0] a,
                             input logic [63:0] b, input bit f, input bit rdy);
    bit push;
    push = 0;
    if (!r) begin
      modelReset();
    end else begin
      if (f && mOpen && (!mPendV || rdy)) begin
        push = 1;
        pSum = mSum; pPc = mPc; pBc = mBc; pOcc = mOcc; pEcc = 16'(mEcc);
        mOpen = 0;
      end
      if (taken && t) begin
        if (mOpen) begin
          push = 1;
          pSum = mSum; pPc = mPc; pBc = mBc; pOcc = mOcc; pEcc = 16'(mEcc);
        end
        mSum = '0; mPc = '0; mBc = '0; mEcc = 0; mOcc = a; mOpen = 1;
      end else if (taken) begin
        if (mOpen) begin
          mSum = mSum + 64'(a[47:0]) + 64'(b[47:0]);
          mPc  = mPc + 32'(a[60:48]) + 32'(b[60:48]);
          mBc  = mBc + 32'd2;
          if (ECC_ON) begin
            mEcc = mEcc + int'(a[63]) + int'(b[63]);
            if (mEcc > 65535) mEcc = 65535;
          end
        end else begin
          mOrphan = 1;
        end
      end
      if (push) mPendV = 1;
      else if (mPendV && rdy) mPendV = 0;
    end
  endtask

  // Drives one cycle from the falling edge, checks against the model before the
  // rising edge, then advances the model and returns at the next falling edge.
  task automatic cycle(input bit r, input bit v, input bit t, input logic [63:0] a,
                       input logic [63:0] b, input bit f, input bit rdy, output bit irSeen);
    bit expReady;
    rst = r; in_valid = v; in_is_top = t; in_result_a = a; in_result_b = b;
    flush = f; out_ready = rdy;
    #1;
    expReady = r && !f && !(mPendV && !rdy);
    irSeen = in_ready;
    modelCheck(expReady);
    @(posedge clock);
    modelUpdate(r, v && expReady, t, a, b, f, rdy);
    if (!r) primed = 1;
    @(negedge clock);
  endtask

  typedef struct {
    bit          r, v, t;
    logic [63:0] a, b;
    bit          f, rdy;
    bit          eIr, eV;
    logic [63:0] eSum;
    logic [31:0] ePc, eBc;
    logic [63:0] eOcc;
    bit          eOrph;
  } vec_t;

  function automatic vec_t V(input bit r, input bit v, input bit t, input logic [63:0] a,
                             input logic [63:0] b, input bit f, input bit rdy, input bit eIr,
                             input bit eV, input logic [63:0] eSum, input logic [31:0] ePc,
                             input logic [31:0] eBc, input logic [63:0] eOcc, input bit eOrph);
    vec_t x;
    x.r = r; x.v = v; x.t = t; x.a = a; x.b = b; x.f = f; x.rdy = rdy;
    x.eIr = eIr; x.eV = eV; x.eSum = eSum; x.ePc = ePc; x.eBc = eBc; x.eOcc = eOcc; x.eOrph = eOrph;
    return x;
  endfunction

  localparam logic [63:0] OCC = 64'h00000040_00000100;
  localparam logic [63:0] X1  = 64'h00000011_00000022;
  localparam logic [63:0] X2  = 64'h00000033_00000044;

  vec_t tbl[$];
  bit   ir;

  initial begin
    rst = 0; in_valid = 0; in_is_top = 0; in_result_a = '0; in_result_b = '0;
    flush = 0; out_ready = 1;
    modelReset();

    // Table: inputs for one cycle, then in_ready seen before the edge and the
    // registered outputs seen after it.
    tbl.push_back(V(0,0,0,64'd0,64'd0,0,1, 0,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,1,1,OCC,64'd0,0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,1,0,mk(1'b0,13'd1,48'd5),mk(1'b0,13'd2,48'd7),0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,1,0,mk(1'b0,13'd3,48'd10),mk(1'b0,13'd4,48'd20),0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,0,0,64'd0,64'd0,1,1, 0,1,64'd42,32'd10,32'd4,OCC,0));
    tbl.push_back(V(1,0,0,64'd0,64'd0,0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,0,0,64'd0,64'd0,1,1, 0,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,1,1,X1,64'd0,0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,1,1,X2,64'd0,0,1, 1,1,64'd0,32'd0,32'd0,X1,0));
    tbl.push_back(V(1,0,0,64'd0,64'd0,0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,0,0,64'd0,64'd0,1,1, 0,1,64'd0,32'd0,32'd0,X2,0));
    tbl.push_back(V(1,0,0,64'd0,64'd0,0,1, 1,0,64'd0,32'd0,32'd0,64'd0,0));
    tbl.push_back(V(1,1,0,mk(1'b0,13'd1,48'd1),mk(1'b0,13'd1,48'd1),0,1, 1,0,64'd0,32'd0,32'd0,64'd0,1));
    tbl.push_back(V(1,0,0,64'd0,64'd0,0,1, 1,0,64'd0,32'd0,32'd0,64'd0,1));

    @(negedge clock);
    cycle(0,0,0,'0,'0,0,1,ir);
    cycle(0,0,0,'0,'0,0,1,ir);

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_pcoeff", 64'(out_pcoeff), 64'd0);
    chk("rst_out_bot_count", 64'(out_bot_count), 64'd0);
    chk("rst_out_occupancy", out_occupancy, 64'd0);
    chk("rst_out_ecc", 64'(out_ecc_errors), 64'd0);
    chk("rst_orphan", 64'(orphan_error), 64'd0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].t, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].rdy, ir);
      chk($sformatf("tbl%0d_in_ready", i), 64'(ir), 64'(tbl[i].eIr));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].eV));
      chk($sformatf("tbl%0d_orphan", i), 64'(orphan_error), 64'(tbl[i].eOrph));
      if (tbl[i].eV) begin
        chk($sformatf("tbl%0d_sum", i), out_sum, tbl[i].eSum);
        chk($sformatf("tbl%0d_pcoeff", i), 64'(out_pcoeff), 64'(tbl[i].ePc));
        chk($sformatf("tbl%0d_bot_count", i), 64'(out_bot_count), 64'(tbl[i].eBc));
        chk($sformatf("tbl%0d_occupancy", i), out_occupancy, tbl[i].eOcc);
      end
    end

    // Backpressure while a closing top arrives
    cycle(0,0,0,'0,'0,0,1,ir);
    cycle(1,1,1,OCC,'0,0,1,ir);
    cycle(1,1,0,mk(1'b0,13'd2,48'd100),mk(1'b0,13'd3,48'd200),0,1,ir);
    cycle(1,1,1,X1,'0,0,0,ir);
    chk("bp_valid_rise", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      cycle(1,1,0,mk(1'b0,13'd1,48'd9),mk(1'b0,13'd1,48'd9),0,0,ir);
      chk("bp_in_ready_low", 64'(ir), 64'd0);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_sum_stable", out_sum, 64'd300);
      chk("bp_pcoeff_stable", 64'(out_pcoeff), 64'd5);
      chk("bp_occ_stable", out_occupancy, OCC);
    end
    cycle(1,1,0,mk(1'b0,13'd1,48'd9),mk(1'b0,13'd1,48'd9),0,1,ir);
    chk("bp_in_ready_release", 64'(ir), 64'd1);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);

    // Closing beat while the previous record is accepted in the same cycle
    cycle(1,1,1,X2,'0,0,1,ir);
    chk("b2b_first_sum", out_sum, 64'd18);
    cycle(1,1,1,X1,'0,0,1,ir);
    chk("b2b_in_ready", 64'(ir), 64'd1);
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    chk("b2b_second_occ", out_occupancy, X2);
    chk("b2b_second_bc", 64'(out_bot_count), 64'd0);

    // ECC flag on lane B
    cycle(0,0,0,'0,'0,0,1,ir);
    cycle(1,1,1,OCC,'0,0,1,ir);
    cycle(1,1,0,mk(1'b0,13'd1,48'd1),mk(1'b1,13'd1,48'd1),0,1,ir);
    cycle(1,0,0,'0,'0,1,1,ir);
    chk("ecc_valid", 64'(out_valid), 64'd1);
    chk("ecc_count", 64'(out_ecc_errors), ECC_ON ? 64'd1 : 64'd0);

    // Reset in the middle of an open top
    cycle(1,1,1,X1,'0,0,1,ir);
    cycle(1,1,0,mk(1'b1,13'd7,48'd77),mk(1'b0,13'd7,48'd77),0,1,ir);
    cycle(0,0,0,'0,'0,0,1,ir);
    cycle(1,0,0,'0,'0,1,1,ir);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", out_sum, 64'd0);
    chk("midrst_pcoeff", 64'(out_pcoeff), 64'd0);
    chk("midrst_bc", 64'(out_bot_count), 64'd0);
    chk("midrst_occ", out_occupancy, 64'd0);
    chk("midrst_ecc", 64'(out_ecc_errors), 64'd0);
    chk("midrst_orphan", 64'(orphan_error), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit r, v, t, f, rdy;
      logic [63:0] a, b;
      r   = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 9) < 7);
      t   = ($urandom_range(0, 9) < 2);
      f   = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 3) != 0);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cycle(r, v, t, a, b, f, rdy, ir);
    end
    cycle(1,0,0,'0,'0,0,1,ir);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/permute_result_accumulator.md
# permute_result_accumulator

Downstream consumer of the two-lane full-permutation pipeline's result stream. Each input beat carries either a top marker with occupancy statistics or two bot results. Each bot result holds a 48-bit summed value, a 13-bit pcoeff count and an ECC flag. The block folds all bot results belonging to one top into per-top totals and emits one totals record per top over a valid/ready handshake to the host-side result writer.

## Interface
- TOTAL_SUM_W, 64, width of per-top summed-data accumulator (≥49)
- TOTAL_CNT_W, 32, width of pcoeff total and bot counter
- clock  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  result beat present
- in_ready  out  1  block accepts beat this cycle
- in_is_top  in  1  beat is a top marker (occupancy), not bot results
- in_result_a  in  64  lane A: [63] ECC, [60:48] pcoeff count, [47:0] sum; top beat: [63:32] busy cycles, [31:0] total cycles
- in_result_b  in  64  lane B, same layout; ignored on top beats
- flush  in  1  close currently open top (end of job)
- out_valid  out  1  totals record present
- out_ready  in  1  consumer accepts record
- out_sum  out  TOTAL_SUM_W  sum of all lane summed values for the top
- out_pcoeff  out  TOTAL_CNT_W  sum of all lane pcoeff counts
- out_bot_count  out  TOTAL_CNT_W  bot results accumulated (2 per bot beat)
- out_occupancy  out  64  top beat lane-A word captured at top open
- out_ecc_errors  out  16  ECC flags seen in this top (saturating)
- orphan_error  out  1  sticky: bot beat arrived with no top open

## Operation
- States: IDLE (no top open), ACCUM (top open).
- Beat accepted when in_valid && in_ready.
- in_ready = rst && !flush && !(out_valid && !out_ready).
- Top beat in IDLE: accumulators cleared, occupancy captured, go ACCUM.
- Top beat in ACCUM: current totals loaded into output register (out_valid=1), accumulators cleared, new occupancy captured, stay ACCUM.
- Bot beat in ACCUM: sum += zext(a[47:0]) + zext(b[47:0]); pcoeff += a[60:48] + b[60:48]; bot_count += 2.
- Bot beat in IDLE: discarded, orphan_error set (cleared only by reset).
- flush in ACCUM with output register free or draining: totals loaded to output register, go IDLE. flush in IDLE: no effect. flush held while output blocked: waits, takes effect when register frees.
- Arithmetic: all accumulators wrap modulo 2^width; ECC counter saturates at 16'hFFFF.
- Output register holds all fields stable while out_valid && !out_ready; cleared out_valid on accept unless reloaded the same cycle.

## Timing
- Reset (rst=0 at posedge): state IDLE, out_valid=0, all out_* = 0, orphan_error=0, accumulators 0; in_ready=0 during reset.
- Latency: out_valid rises the cycle after the closing top beat or flush is taken.
- Closing beat and out_ready accepting previous record in same cycle: both occur, new record visible next cycle, no bubble.
- Throughput: one input beat per cycle while out_ready high.
- Reset mid-top discards open totals and any pending record.

## Configuration
- PERMUTE_RESULT_ECC_CHECK_EN defined: lane bit 63 counted per bot result into out_ecc_errors (0, 1 or 2 per beat).
- Undefined: bit 63 ignored, out_ecc_errors tied 0, counter logic absent.

## Structure
- Shared package permute_result_pkg: RESULT_W=64, SUM_W=48, PCOEFF_LSB=48, PCOEFF_W=13, ECC_BIT=63, OCC_BUSY_LSB=32, packed totals record typedef.
- One sub-module: permute_result_lane_unpack (splits a 64-bit lane word into sum/pcoeff/ecc fields), instantiated per lane.

## Test plan
- Top beat a=64'h00000040_00000100; bot beats (sumA=5,cntA=1,sumB=7,cntB=2), (10,3,20,4); flush -> one record: sum 42, pcoeff 10, bot_count 4, occupancy 64'h00000040_00000100, state IDLE.
- Two consecutive top beats -> first record sum 0, pcoeff 0, bot_count 0; second top remains open.
- out_ready low while closing top arrives -> out_valid held, fields stable, in_ready 0; out_ready high -> accepted, in_ready 1 next cycle.
- Bot beat before any top -> no record, orphan_error=1 until reset.
- Lane B with bit 63 set in one bot beat then flush -> out_ecc_errors=1 with macro, 0 without.
- rst low for one cycle mid-top, then flush -> no record, out_valid 0, all outputs 0.
